// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core's data-side store buffer.
//   SB_DEPTH   : default number of buffered stores
//   SB_DW/AW   : default data / byte-address widths
//   SB_PTR_W   : pointer width for the default depth
//   sb_entry_t : one buffered store {valid, word address, data}
package mips_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic                valid;
    logic [SB_AW-3:0]    waddr;
    logic [SB_DW-1:0]    data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-match search over the store buffer entries.
// Ports:
//   entries  : entry array (index = slot)
//   head     : oldest slot
//   tail     : next free slot (youngest is tail-1)
//   waddr    : lookup word address
//   hit      : a valid entry matches
//   hit_data : data of the youngest matching entry
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]         entries,
  input  logic      [$clog2(DEPTH)-1:0] head,
  input  logic      [$clog2(DEPTH)-1:0] tail,
  input  logic      [SB_AW-3:0]         waddr,
  output logic                          hit,
  output logic      [SB_DW-1:0]         hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Walk backward from tail-1; the first match found is the youngest.
  // The walk stops once the head slot has been examined.
  always_comb begin
    logic [PW-1:0] idx;
    logic          done;
    hit      = 1'b0;
    hit_data = '0;
    done     = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(i + 1);
      if (!done && !hit && entries[idx].valid && (entries[idx].waddr == waddr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
      if (idx == head) begin
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the single-cycle MIPS core data port and a data memory
// whose write port may stall. Stores are queued and drained via valid/ready;
// loads read memory combinationally with youngest-store forwarding.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   memwrite, memread      : core store / load request
//   addr, writedata        : core byte address, store data
//   readdata               : load result to core
//   stall                  : store cannot be accepted (buffer full)
//   sb_empty               : no stores pending
//   mem_raddr, mem_rdata   : memory read port (combinational)
//   mem_wvalid/wready      : write handshake for the head entry
//   mem_waddr, mem_wdata   : head entry address (word aligned) and data
// Optional build macro STORE_BUFFER_MERGE_EN: a store hitting the youngest
// entry (when that entry is not the head) overwrites it instead of pushing.
// DW/AW must match the entry widths in mips_pkg.
module store_buffer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned DW    = SB_DW,
  parameter int unsigned AW    = SB_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          memwrite,
  input  logic          memread,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          sb_empty,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t [DEPTH-1:0] ent_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;

  logic          full, push, pop, merge;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full = (count_q == CW'(DEPTH));

`ifdef STORE_BUFFER_MERGE_EN
  logic [PW-1:0] last;
  assign last = tail_q - PW'(1);
  // count > 1 guarantees the youngest entry is not the head being drained.
  assign merge = memwrite && (count_q > CW'(1)) && ent_q[last].valid &&
                 (ent_q[last].waddr == addr[AW-1:2]);
`else
  assign merge = 1'b0;
`endif

  assign push       = memwrite && !full && !merge;
  assign pop        = mem_wvalid && mem_wready;
  // Held even if a pop frees a slot this cycle; the core retries next cycle.
  assign stall      = memwrite && full && !merge;
  assign sb_empty   = (count_q == '0);
  assign mem_wvalid = !sb_empty;
  assign mem_waddr  = {ent_q[head_q].waddr, 2'b00};
  assign mem_wdata  = ent_q[head_q].data;
  assign mem_raddr  = addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= '{valid: 1'b1, waddr: addr[AW-1:2], data: writedata};
        tail_q        <= tail_q + PW'(1);
      end
`ifdef STORE_BUFFER_MERGE_EN
      if (merge) begin
        ent_q[last].data <= writedata;
      end
`endif
      if (pop) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH)
  ) u_fwd (
    .entries (ent_q),
    .head    (head_q),
    .tail    (tail_q),
    .waddr   (addr[AW-1:2]),
    .hit     (fwd_hit),
    .hit_data(fwd_data)
  );

  // Same-cycle store is not yet in the buffer, so it is never forwarded.
  assign readdata = (memread && fwd_hit) ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic checked against a queue-based model of the buffer contents.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        memwrite = 1'b0, memread = 1'b0, mem_wready = 1'b0;
  logic [31:0] addr = '0, writedata = '0, mem_rdata = '0;
  logic [31:0] readdata, mem_raddr, mem_waddr, mem_wdata;
  logic        stall, sb_empty, mem_wvalid;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH(DEPTH),
    .DW   (32),
    .AW   (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memwrite  (memwrite),
    .memread   (memread),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .sb_empty  (sb_empty),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];   // pending stores, oldest first
  int unsigned total = 0;
  int unsigned bad = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a, hold_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs against the model, then advance
  // the model to what the coming clock edge should produce.
  task automatic step(input logic mw, input logic mr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic wr);
    logic        full, mrg, push, pop;
    logic [31:0] exp_rd;
    ent_t        e;
    @(negedge clk);
    memwrite = mw; memread = mr; addr = a; writedata = wd; mem_rdata = rd; mem_wready = wr;
    #1;
    full = (q.size() == DEPTH);
    mrg  = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
    if (mw && q.size() >= 2 && q[q.size()-1].w == a[31:2]) mrg = 1'b1;
`endif
    exp_rd = rd;
    if (mr) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].w == a[31:2]) exp_rd = q[i].d;  // later index = younger
      end
    end
    check("readdata", readdata, exp_rd);
    check("mem_raddr", mem_raddr, a);
    check("stall", stall, mw && full && !mrg);
    check("sb_empty", sb_empty, q.size() == 0);
    check("wvalid", mem_wvalid, q.size() != 0);
    if (q.size() != 0) begin
      check("waddr", mem_waddr, {q[0].w, 2'b00});
      check("wdata", mem_wdata, q[0].d);
    end
    if (hold_v) begin
      check("hold_waddr", mem_waddr, hold_a);
      check("hold_wdata", mem_wdata, hold_d);
    end
    pop    = (q.size() != 0) && wr;
    push   = mw && !full && !mrg;
    hold_v = (q.size() != 0) && !wr;
    if (q.size() != 0) begin
      hold_a = {q[0].w, 2'b00};
      hold_d = q[0].d;
    end
    if (mrg) q[q.size()-1].d = wd;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.w = a[31:2];
      e.d = wd;
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    memwrite = 1'b0; memread = 1'b0; mem_wready = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_wvalid", mem_wvalid, 1'b0);
    check("rst_empty", sb_empty, 1'b1);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    hold_v = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single store then drain.
    step(1'b1, 1'b0, 32'h54, 32'hDEADBEEF, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t1_wvalid", mem_wvalid, 1'b1);
    check("t1_waddr", mem_waddr, 32'h54);
    check("t1_wdata", mem_wdata, 32'hDEADBEEF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t1_wvalid_off", mem_wvalid, 1'b0);
    check("t1_empty", sb_empty, 1'b1);

    // Forwarding of the youngest store.
    do_reset();
    step(1'b1, 1'b0, 32'h50, 32'h11, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h50, 32'h22, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h52, 32'h0, 32'h99, 1'b0);
    check("fwd_readdata", readdata, 32'h22);

    // Backpressure with a full buffer.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'(i), 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h200, 32'h55, 32'h0, 1'b0);
    check("bp_stall", stall, 1'b1);
    step(1'b1, 1'b0, 32'h200, 32'h55, 32'h0, 1'b1);
    check("bp_stall_pop", stall, 1'b1);
    step(1'b1, 1'b0, 32'h200, 32'h55, 32'h0, 1'b0);
    check("bp_stall_retry", stall, 1'b0);
    step(1'b0, 1'b1, 32'h200, 32'h0, 32'h1234, 1'b0);
    check("bp_pushed_fwd", readdata, 32'h55);

    // Miss path.
    do_reset();
    step(1'b1, 1'b0, 32'h60, 32'h777, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h64, 32'h0, 32'hABCD, 1'b0);
    check("miss_readdata", readdata, 32'hABCD);
    check("miss_raddr", mem_raddr, 32'h64);

    // Randomized traffic with random backpressure, crossing pointer wrap.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset while stalled with a full buffer.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'(i + 7), 32'h0, 1'b0);
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h90; mem_wready = 1'b0;
    #1;
    check("arst_pre_stall", stall, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_wvalid", mem_wvalid, 1'b0);
    check("arst_stall", stall, 1'b0);
    check("arst_empty", sb_empty, 1'b1);
    @(negedge clk);
    memwrite = 1'b0;
    reset_n  = 1'b1;
    q.delete();
    hold_v = 1'b0;
    step(1'b0, 1'b1, 32'h80, 32'h0, 32'h31, 1'b1);
    check("arst_discarded", readdata, 32'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
